// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter: one log-stage (16, 8, 4, 2, 1) per cycle over a fixed
// CNT_W-cycle iteration, with a sticky bit collecting every discarded bit.
module shift_right_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [CNT_W-1:0] cnt,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] B,
  output logic             sticky,
  output logic             busy
);

  localparam int K_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] count;
  logic             mode;
  logic             sign;
  logic             fill;
  logic             sticky_acc;
  logic [K_W-1:0]   k;
  logic [WIDTH-1:0] step_data;
  logic             step_sticky;

  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                   input logic f,
                                                   input logic [K_W-1:0] kk);
    logic [2*WIDTH-1:0] ext;
    ext = {{WIDTH{f}}, d};
    ext = ext >> (1 << kk);
    return ext[WIDTH-1:0];
  endfunction

  function automatic logic stage_lost(input logic [WIDTH-1:0] d,
                                      input logic [K_W-1:0] kk);
    logic [WIDTH-1:0] mask;
    mask = (WIDTH'(1) << (1 << kk)) - WIDTH'(1);
    return |(d & mask);
  endfunction

  // Fill is the operand sign captured at accept, gated by the mode captured with it.
  assign fill = mode & sign;

  always_comb begin
    step_data   = data;
    step_sticky = sticky_acc;
    if (count[k]) begin
      step_data   = stage_shift(data, fill, k);
      step_sticky = sticky_acc | stage_lost(data, k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (k == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= '0;
      count      <= '0;
      mode       <= 1'b0;
      sign       <= 1'b0;
      sticky_acc <= 1'b0;
      k          <= '0;
      B          <= '0;
      sticky     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data       <= A;
            count      <= cnt;
            mode       <= arith;
            sign       <= A[WIDTH-1];
            sticky_acc <= 1'b0;
            k          <= K_W'(CNT_W - 1);
          end
        end
        SHIFT: begin
          data       <= step_data;
          sticky_acc <= step_sticky;
          k          <= k - K_W'(1);
          // Output registers load only on the final stage so B holds between results.
          if (k == '0) begin
            B      <= step_data;
            sticky <= step_sticky;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: latency, shift results, sticky, stall and abort.
module tb_shift_right_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [4:0]  cnt;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] B;
  logic        sticky;
  logic        busy;

  int checks = 0;
  int errors = 0;

  shift_right_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .cnt(cnt), .arith(arith), .out_valid(out_valid),
    .out_ready(out_ready), .B(B), .sticky(sticky), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input string name, input logic [31:0] a,
                          input logic [4:0] c, input logic ar);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: in_ready=%b, required 1", name, in_ready);
    end
    A = a; cnt = c; arith = ar; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [31:0] exp_b,
                             input logic exp_s);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, required 5", name, lat);
    end
    checks++;
    if (B !== exp_b) begin
      errors++;
      $display("FAIL %s B: got %h, required %h", name, B, exp_b);
    end
    checks++;
    if (sticky !== exp_s) begin
      errors++;
      $display("FAIL %s sticky: got %b, required %b", name, sticky, exp_s);
    end
  endtask

  task automatic finish_xfer(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
               name, out_valid, in_ready, busy);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [4:0] c,
                        input logic ar, input logic [31:0] exp_b, input logic exp_s);
    do_start(name, a, c, ar);
    wait_result(name, exp_b, exp_s);
    finish_xfer(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (B !== 32'h0 || sticky !== 1'b0 || out_valid !== 1'b0 ||
        in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: B=%h sticky=%b out_valid=%b in_ready=%b busy=%b, required 0 0 0 1 0",
               B, sticky, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_logical();
    run_op("logical_1", 32'h80000001, 5'd1, 1'b0, 32'h40000000, 1'b1);
    run_op("logical_3", 32'h0000000F, 5'd3, 1'b0, 32'h00000001, 1'b1);
  endtask

  task automatic test_arith_full();
    run_op("arith_31", 32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 1'b0);
    run_op("logic_31", 32'h80000000, 5'd31, 1'b0, 32'h00000001, 1'b0);
    run_op("arith_4", 32'hF0000000, 5'd4, 1'b1, 32'hFF000000, 1'b0);
  endtask

  task automatic test_zero_mixed();
    run_op("zero", 32'h12345678, 5'd0, 1'b1, 32'h12345678, 1'b0);
    run_op("mixed_20", 32'h12345678, 5'd20, 1'b0, 32'h00000123, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_start("stall", 32'hA5A5A5A5, 5'd8, 1'b1);
    wait_result("stall", 32'hFFA5A5A5, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        A = 32'hDEADBEEF; cnt = 5'd1; arith = 1'b0; in_valid = 1'b1;
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (B !== 32'hFFA5A5A5 || sticky !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall cycle %0d: B=%h sticky=%b in_ready=%b out_valid=%b, required ffa5a5a5 1 0 1",
                 i, B, sticky, in_ready, out_valid);
      end
    end
    finish_xfer("stall");
    run_op("b2b", 32'h87654321, 5'd12, 1'b1, 32'hFFF87654, 1'b1);
  endtask

  task automatic test_reset_mid();
    int seen;
    do_start("abort", 32'hFFFF0000, 5'd7, 1'b1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (B !== 32'h0 || sticky !== 1'b0 || out_valid !== 1'b0 ||
        in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort reset: B=%h sticky=%b out_valid=%b in_ready=%b busy=%b, required 0 0 0 1 0",
               B, sticky, out_valid, in_ready, busy);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort out_valid: seen %0d cycles high, required 0", seen);
    end
    run_op("recover", 32'h0000000F, 5'd3, 1'b0, 32'h00000001, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; cnt = '0; arith = 1'b0; out_ready = 1'b0;
    test_reset();
    test_logical();
    test_arith_full();
    test_zero_mixed();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
